// File: rtl/convolve_pkg.sv
// Shared types and sizing helpers for the convolve sequencer.
// Exports the state enum, beat-count functions and a counter-width helper.
package convolve_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        KERNEL,
        STREAM,
        DRAIN,
        FINISH
    } state_t;

    function automatic int num_k(input int ksize);
        return ksize * ksize;
    endfunction

    function automatic int num_pix(input int len);
        return len * len;
    endfunction

    function automatic int num_out(input int len, input int ksize);
        return (len - ksize + 1) * (len - ksize + 1);
    endfunction

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/conv_beat_counter.sv
// Up-counter with sync clear, enable, saturation at MAX and a terminal flag.
// Ports: clk, reset, clr_i, en_i in; count_o (0..MAX), last_o (count==MAX-1) out.
module conv_beat_counter
    import convolve_pkg::*;
#(
    parameter int MAX = 9,
    parameter int W   = cnt_w(MAX)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         last_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != W'(MAX))) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    // Terminal flag fires on the beat that completes the phase, so the
    // owning FSM can leave on that same handshake without a bubble.
    assign last_o  = (count_q == W'(MAX - 1));

endmodule

// File: rtl/convolve_ctrl.sv
// Sequencer for the convolve datapath: kernel load, pixel stream, drain.
// Ports: clk/reset/start, in_* stream, conv_* datapath pins, out_* results, busy/done/error.
module convolve_ctrl
    import convolve_pkg::*;
#(
    parameter int BITS        = 9,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_LENGTH  = 16,
    parameter int DRAIN_MAX   = 128
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [BITS-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            conv_reset,
    output logic [BITS-1:0] conv_kernel_in,
    output logic            conv_kernel_write_en,
    output logic [BITS-1:0] conv_img_input,
    output logic            conv_shift_write_en,
    input  logic            conv_output_valid,
    input  logic [BITS-1:0] conv_img_output,
    output logic [BITS-1:0] out_data,
    output logic            out_valid,
    output logic [cnt_w(num_out(IMG_LENGTH, KERNEL_SIZE))-1:0] out_count,
    output logic            busy,
    output logic            done,
    output logic            error
);

    localparam int NUM_K   = num_k(KERNEL_SIZE);
    localparam int NUM_PIX = num_pix(IMG_LENGTH);
    localparam int NUM_OUT = num_out(IMG_LENGTH, KERNEL_SIZE);
    localparam int OCW     = cnt_w(NUM_OUT);

    state_t state_q, state_d;

    logic            conv_reset_q, conv_reset_d;
    logic [BITS-1:0] kin_q, kin_d;
    logic            kwe_q, kwe_d;
    logic [BITS-1:0] img_q, img_d;
    logic            swe_q, swe_d;
    logic [BITS-1:0] out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic [OCW-1:0]  out_count_q, out_count_d;
    logic            error_q, error_d;

    logic accept_start;
    logic hs;
    logic in_kernel;
    logic in_stream;
    logic in_drain;
    logic out_full;
    logic fwd;
    logic k_last;
    logic p_last;
    logic d_last;

    logic [cnt_w(NUM_K)-1:0]     k_count;
    logic [cnt_w(NUM_PIX)-1:0]   p_count;
    logic [cnt_w(DRAIN_MAX)-1:0] d_count;

    assign in_kernel    = (state_q == KERNEL);
    assign in_stream    = (state_q == STREAM);
    assign in_drain     = (state_q == DRAIN);
    assign accept_start = (state_q == IDLE) && start;
    assign in_ready     = in_kernel || in_stream;
    assign hs           = in_valid && in_ready;
    assign out_full     = (out_count_q == OCW'(NUM_OUT));
    // Results only pass while the datapath is live and before saturation.
    assign fwd          = (in_stream || in_drain) && conv_output_valid
                          && !out_full;

    conv_beat_counter #(.MAX(NUM_K)) u_kcnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (accept_start),
        .en_i    (hs && in_kernel),
        .count_o (k_count),
        .last_o  (k_last)
    );

    conv_beat_counter #(.MAX(NUM_PIX)) u_pcnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (accept_start),
        .en_i    (hs && in_stream),
        .count_o (p_count),
        .last_o  (p_last)
    );

    conv_beat_counter #(.MAX(DRAIN_MAX)) u_dcnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (accept_start),
        .en_i    (in_drain),
        .count_o (d_count),
        .last_o  (d_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = KERNEL;
            KERNEL:  if (hs && k_last) state_d = STREAM;
            STREAM:  if (hs && p_last) state_d = DRAIN;
            DRAIN:   if (out_full || d_last) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        conv_reset_d = accept_start;
        kwe_d        = hs && in_kernel;
        kin_d        = kwe_d ? in_data : kin_q;
        swe_d        = hs && in_stream;
        img_d        = swe_d ? in_data : img_q;
        out_valid_d  = fwd;
        out_data_d   = fwd ? conv_img_output : out_data_q;
        out_count_d  = out_count_q;
        error_d      = error_q;
        if (accept_start) begin
            out_count_d = '0;
            error_d     = 1'b0;
        end else begin
            if (fwd) begin
                out_count_d = out_count_q + OCW'(1);
            end
            // Timeout only when drain budget expires short of a full image.
            if (in_drain && d_last && !out_full) begin
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            conv_reset_q <= 1'b1;
            kin_q        <= '0;
            kwe_q        <= 1'b0;
            img_q        <= '0;
            swe_q        <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_count_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            conv_reset_q <= conv_reset_d;
            kin_q        <= kin_d;
            kwe_q        <= kwe_d;
            img_q        <= img_d;
            swe_q        <= swe_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_count_q  <= out_count_d;
            error_q      <= error_d;
        end
    end

    assign conv_reset           = conv_reset_q;
    assign conv_kernel_in       = kin_q;
    assign conv_kernel_write_en = kwe_q;
    assign conv_img_input       = img_q;
    assign conv_shift_write_en  = swe_q;
    assign out_data             = out_data_q;
    assign out_valid            = out_valid_q;
    assign out_count            = out_count_q;
    assign error                = error_q;
    assign busy                 = (state_q != IDLE);
    assign done                 = (state_q == FINISH);

endmodule

// File: tb/tb_convolve_ctrl.sv
// Bench for convolve_ctrl with a behavioural convolve model and scoreboard.
// Exercises reset, handshakes, drain timeout, abort and back-to-back jobs.
module tb_convolve_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       conv_reset;
    logic [8:0] conv_kernel_in;
    logic       conv_kernel_write_en;
    logic [8:0] conv_img_input;
    logic       conv_shift_write_en;
    logic       conv_output_valid;
    logic [8:0] conv_img_output;
    logic [8:0] out_data;
    logic       out_valid;
    logic [7:0] out_count;
    logic       busy;
    logic       done;
    logic       error;

    convolve_ctrl dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .in_data              (in_data),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .conv_reset           (conv_reset),
        .conv_kernel_in       (conv_kernel_in),
        .conv_kernel_write_en (conv_kernel_write_en),
        .conv_img_input       (conv_img_input),
        .conv_shift_write_en  (conv_shift_write_en),
        .conv_output_valid    (conv_output_valid),
        .conv_img_output      (conv_img_output),
        .out_data             (out_data),
        .out_valid            (out_valid),
        .out_count            (out_count),
        .busy                 (busy),
        .done                 (done),
        .error                (error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int kpulse, spulse, obeats, done_cnt;
    int last_shift_cyc, done_cyc;
    bit silent = 1'b0;
    bit hold = 1'b0;
    logic [8:0] kern_w [9];
    logic [8:0] pix [256];
    logic [8:0] exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Behavioural datapath: 3x3 window over a 16-wide raster, valid
    // one cycle after each shift that completes an interior window.
    logic [8:0] m_kern [9];
    logic [8:0] m_img [256];
    int m_kidx = 0;
    int m_pidx = 0;
    always @(posedge clk) begin
        cyc++;
        conv_output_valid <= 1'b0;
        if (conv_reset) begin
            m_kidx = 0;
            m_pidx = 0;
        end else begin
            if (conv_kernel_write_en && m_kidx < 9) begin
                m_kern[m_kidx] = conv_kernel_in;
                m_kidx++;
            end
            if (conv_shift_write_en && m_pidx < 256) begin
                int r, c, s;
                r = m_pidx / 16;
                c = m_pidx % 16;
                m_img[m_pidx] = conv_img_input;
                if (r >= 2 && c >= 2) begin
                    s = 0;
                    for (int ky = 0; ky < 3; ky++)
                        for (int kx = 0; kx < 3; kx++)
                            s += int'(m_kern[ky*3+kx]) *
                                 int'(m_img[(r-2+ky)*16 + (c-2+kx)]);
                    conv_img_output   <= 9'(s);
                    conv_output_valid <= !silent;
                end
                m_pidx++;
            end
        end
    end

    always @(negedge clk) begin
        if (conv_kernel_write_en) kpulse++;
        if (conv_shift_write_en) begin
            spulse++;
            last_shift_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_valid) begin
            obeats++;
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                chk("out_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic clr_counts();
        kpulse = 0;
        spulse = 0;
        obeats = 0;
        done_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_job(input bit skip_start);
        clr_counts();
        if (!skip_start) begin
            start = 1'b1;
            tick();
            start = hold;
        end
        chk("clear_busy", int'(busy), 1);
        chk("clear_conv_reset", int'(conv_reset), 1);
        chk("clear_error", int'(error), 0);
        chk("clear_out_count", int'(out_count), 0);
    endtask

    task automatic send_words(input int gap, input int npix,
                              input bit poke);
        int idx = 0;
        int budget = 0;
        int total = 9 + npix;
        bit hs;
        while (idx < total && budget < 6000) begin
            in_valid = ($urandom_range(0, 99) >= gap);
            in_data  = (idx < 9) ? kern_w[idx] : pix[idx-9];
            start    = hold | (poke && idx > 59 && idx < 62);
            hs       = in_valid && in_ready;
            tick();
            if (hs) begin
                if (idx >= 9) begin
                    int p = idx - 9;
                    if (!silent && p / 16 >= 2 && p % 16 >= 2)
                        exp_q.push_back(pix[p-17]);
                end
                idx++;
            end
            budget++;
        end
        in_valid = 1'b0;
        start = hold;
        if (idx < total) chk("send_timeout", idx, total);
    endtask

    task automatic finish_job(input int exp_err, input int exp_cnt);
        int n = 0;
        while (!done && n < 1000) begin
            tick();
            n++;
        end
        chk("done_seen", int'(done), 1);
        chk("error", int'(error), exp_err);
        chk("out_count", int'(out_count), exp_cnt);
        tick();
        chk("idle_busy", int'(busy), 0);
        chk("done_pulses", done_cnt, 1);
        chk("kernel_pulses", kpulse, 9);
        chk("shift_pulses", spulse, 256);
        chk("out_beats", obeats, exp_cnt);
        chk("queue_left", exp_q.size(), 0);
    endtask

    typedef struct {
        logic rst, st, iv;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [8];

    initial begin
        // exp = {busy, in_ready, conv_reset, kwe, swe, done, error, out_valid}
        tbl[0] = '{1'b1, 1'b0, 1'b1, 8'b00100000};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 8'b00000000};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 8'b00000000};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 8'b10100000};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 8'b11000000};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 8'b11010000};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 8'b00100000};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 8'b00000000};

        for (int i = 0; i < 9; i++) kern_w[i] = (i == 4) ? 9'd1 : 9'd0;
        for (int i = 0; i < 256; i++) pix[i] = 9'(i);
        clr_counts();
        in_data = '0;

        for (int i = 0; i < 8; i++) begin
            logic [7:0] act;
            reset    = tbl[i].rst;
            start    = tbl[i].st;
            in_valid = tbl[i].iv;
            tick();
            act = {busy, in_ready, conv_reset, conv_kernel_write_en,
                   conv_shift_write_en, done, error, out_valid};
            vectors++;
            if (act !== tbl[i].exp) begin
                miscompares++;
                $display("FAIL table[%0d]: got %b want %b", i, act,
                         tbl[i].exp);
            end
        end
        reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        tick();

        // Identity kernel, ramp image, no gaps.
        begin_job(0);
        send_words(0, 256, 0);
        finish_job(0, 196);

        // Same job with ~50% valid gaps.
        begin_job(0);
        send_words(50, 256, 0);
        finish_job(0, 196);

        // Datapath never reports results: drain timeout.
        silent = 1'b1;
        begin_job(0);
        send_words(0, 256, 0);
        finish_job(1, 0);
        chk("timeout_cycles", done_cyc - last_shift_cyc, 128);
        silent = 1'b0;

        // Random image, start poked mid-stream (clears error from above).
        for (int i = 0; i < 256; i++) pix[i] = 9'($urandom_range(0, 511));
        begin_job(0);
        send_words(30, 256, 1);
        finish_job(0, 196);

        // Abort after 100 pixels with reset.
        begin_job(0);
        send_words(0, 100, 0);
        reset = 1'b1;
        tick();
        chk("abort_busy", int'(busy), 0);
        chk("abort_conv_reset", int'(conv_reset), 1);
        chk("abort_done", int'(done), 0);
        reset = 1'b0;
        tick();
        chk("abort_no_done", done_cnt, 0);
        exp_q.delete();

        begin_job(0);
        send_words(20, 256, 0);
        finish_job(0, 196);

        // Back-to-back with start held high.
        hold = 1'b1;
        begin_job(0);
        send_words(0, 256, 0);
        finish_job(0, 196);
        tick();
        hold = 1'b0;
        start = 1'b0;
        begin_job(1);
        send_words(0, 256, 0);
        finish_job(0, 196);

        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule
